button_input_conditioner: RTL

- Front end that produces the control unit's button and test inputs: botonSleep, botonAwake, botonFeed, botonPlay, giro, botonTest, pulseTest.
- Synchronises and debounces the raw board buttons and the tilt sensor, then converts clean presses into single-cycle pulses.
- Implements the test-entry gesture: a long hold of the test button, followed by N short presses, delivers botonTest with pulseTest = N.

---
 rtl/button_input_conditioner_pkg.sv | 17 +
 rtl/button_input_conditioner_if.sv | 38 +++
 rtl/button_input_conditioner_debounce_pulse.sv | 43 ++++
 rtl/button_input_conditioner.sv | 125 ++++++++++++
 4 files changed

// File: rtl/button_input_conditioner_pkg.sv
// Shared constants and test-FSM encoding for the button front end.
// The control unit and its bench pick up the default timing from here.
package button_input_conditioner_pkg;

    localparam int DEBOUNCE_CYCLES_DEF    = 4;
    localparam int LONG_PRESS_CYCLES_DEF  = 20;
    localparam int TEST_WINDOW_CYCLES_DEF = 30;
    localparam int CNT_W_DEF              = 4;

    typedef logic [1:0] test_state_t;

    localparam test_state_t IDLE  = 2'd0;
    localparam test_state_t HOLD  = 2'd1;
    localparam test_state_t ARMED = 2'd2;
    localparam test_state_t COUNT = 2'd3;

endpackage

// File: rtl/button_input_conditioner_if.sv
// Raw board inputs and conditioned control-unit inputs of the button front end.
interface button_input_conditioner_if
    import button_input_conditioner_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             rawSleep;
    logic             rawAwake;
    logic             rawFeed;
    logic             rawPlay;
    logic             rawTest;
    logic             rawGiro;

    logic             botonSleep;
    logic             botonAwake;
    logic             botonFeed;
    logic             botonPlay;
    logic             giro;
    logic             botonTest;
    logic [CNT_W-1:0] pulseTest;
    logic             testArmed;
    test_state_t      test_state;

    // No back-pressure: every boton* is a one-cycle strobe the consumer must take
    // on that cycle; pulseTest is qualified by botonTest and then holds its value.
    modport master (
        output rawSleep, rawAwake, rawFeed, rawPlay, rawTest, rawGiro,
        input  botonSleep, botonAwake, botonFeed, botonPlay, giro,
        input  botonTest, pulseTest, testArmed, test_state
    );

    modport slave (
        input  rawSleep, rawAwake, rawFeed, rawPlay, rawTest, rawGiro,
        output botonSleep, botonAwake, botonFeed, botonPlay, giro,
        output botonTest, pulseTest, testArmed, test_state
    );

endinterface

// File: rtl/button_input_conditioner_debounce_pulse.sv
// Two-flop synchroniser, stability-counter debounce and registered rising-edge pulse.
module debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            // Any sample agreeing with the current level restarts the stability run.
            if (sync2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync2;
                    rise  <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/button_input_conditioner.sv
// Button/tilt front end: six debounced channels plus the long-hold-then-count
// test-entry gesture that delivers botonTest with the press count on pulseTest.
module button_input_conditioner
    import button_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_PRESS_CYCLES  = LONG_PRESS_CYCLES_DEF,
    parameter int TEST_WINDOW_CYCLES = TEST_WINDOW_CYCLES_DEF,
    parameter int CNT_W              = CNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    button_input_conditioner_if.slave   bus
);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int WIN_W  = $clog2(TEST_WINDOW_CYCLES + 1);

    logic              test_level;
    logic              test_rise;

    test_state_t       state;
    test_state_t       state_n;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_n;
    logic [WIN_W-1:0]  window_cnt;
    logic [WIN_W-1:0]  window_cnt_n;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_n;
    logic              deliver;

    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sleep (
        .clk(clk), .rst(rst), .raw(bus.rawSleep), .level(), .rise(bus.botonSleep)
    );
    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_awake (
        .clk(clk), .rst(rst), .raw(bus.rawAwake), .level(), .rise(bus.botonAwake)
    );
    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_feed (
        .clk(clk), .rst(rst), .raw(bus.rawFeed), .level(), .rise(bus.botonFeed)
    );
    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_play (
        .clk(clk), .rst(rst), .raw(bus.rawPlay), .level(), .rise(bus.botonPlay)
    );
    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_test (
        .clk(clk), .rst(rst), .raw(bus.rawTest), .level(test_level), .rise(test_rise)
    );
    // The tilt sensor is consumed as a level only.
    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_giro (
        .clk(clk), .rst(rst), .raw(bus.rawGiro), .level(bus.giro), .rise()
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            window_cnt    <= '0;
            count         <= '0;
            bus.botonTest <= 1'b0;
            bus.pulseTest <= '0;
        end else begin
            state         <= state_n;
            hold_cnt      <= hold_cnt_n;
            window_cnt    <= window_cnt_n;
            count         <= count_n;
            bus.botonTest <= deliver;
            if (deliver) begin
                bus.pulseTest <= count;
            end
        end
    end

    always_comb begin
        state_n      = state;
        hold_cnt_n   = hold_cnt;
        window_cnt_n = window_cnt;
        count_n      = count;
        deliver      = 1'b0;
        case (state)
            IDLE: begin
                if (test_rise) begin
                    state_n    = HOLD;
                    hold_cnt_n = '0;
                end
            end
            HOLD: begin
                if (!test_level) begin
                    state_n = IDLE;
                end else if (hold_cnt == HOLD_W'(LONG_PRESS_CYCLES - 1)) begin
                    state_n = ARMED;
                end else begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end
            ARMED: begin
                if (!test_level) begin
                    state_n      = COUNT;
                    count_n      = '0;
                    window_cnt_n = '0;
                end
            end
            COUNT: begin
                // A press on the expiry edge takes priority and restarts the window.
                if (test_rise) begin
                    if (count != {CNT_W{1'b1}}) begin
                        count_n = count + 1'b1;
                    end
                    window_cnt_n = '0;
                end else if (!test_level) begin
                    if (window_cnt == WIN_W'(TEST_WINDOW_CYCLES - 1)) begin
                        state_n = IDLE;
                        deliver = (count != '0);
                    end else begin
                        window_cnt_n = window_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.testArmed  = (state == ARMED) || (state == COUNT);
        bus.test_state = state;
    end

endmodule
